// File: rtl/booth_r4_multiplier_if.sv
// rtl/booth_r4_multiplier_if.sv - start/operand/result bundle between multdiv control and the Booth multiplier
interface booth_r4_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             is_signed;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_result_hi;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, is_signed, data_operandA, data_operandB,
        input  data_result, data_result_hi, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, is_signed, data_operandA, data_operandB,
        output data_result, data_result_hi, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/booth_r4_multiplier.sv
// rtl/booth_r4_multiplier.sv - sequential radix-4 Booth multiplier, signed/unsigned, full 2*WIDTH product
module booth_r4_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    booth_r4_multiplier_if.slave  mul
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int XW   = WIDTH + 2;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   mcand_q, mcand_d;
    logic [XW-1:0]   acc_q, acc_d;
    logic [XW-1:0]   mplr_q, mplr_d;
    logic            guard_q, guard_d;
    logic            signed_q, signed_d;
    logic            exc_q, exc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [XW:0]     addend;
    logic [XW:0]     sum;
    logic            neg;
    logic [XW-1:0]   acc_sh, mplr_sh;
    logic [WIDTH-1:0] lo_fin, hi_fin;
    logic            exc_fin;

    // Booth recoding of {mplr[1:0], guard}; subtraction reuses the adder via invert + carry-in.
    always_comb begin
        addend = '0;
        neg    = 1'b0;
        unique case ({mplr_q[1:0], guard_q})
            3'b001, 3'b010: addend = {mcand_q[XW-1], mcand_q};
            3'b011:         addend = {mcand_q, 1'b0};
            3'b100: begin
                addend = {mcand_q, 1'b0};
                neg    = 1'b1;
            end
            3'b101, 3'b110: begin
                addend = {mcand_q[XW-1], mcand_q};
                neg    = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum     = {acc_q[XW-1], acc_q} + (addend ^ {(XW+1){neg}}) + {{XW{1'b0}}, neg};
    assign acc_sh  = {sum[XW], sum[XW:2]};
    assign mplr_sh = {sum[1:0], mplr_q[XW-1:2]};
    assign lo_fin  = mplr_sh[WIDTH-1:0];
    assign hi_fin  = {acc_sh[WIDTH-3:0], mplr_sh[XW-1:WIDTH]};
    assign exc_fin = signed_q ? (hi_fin != {WIDTH{lo_fin[WIDTH-1]}}) : (hi_fin != '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplr_d   = mplr_q;
        guard_d  = guard_q;
        signed_d = signed_q;
        exc_d    = exc_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (mul.ctrl_MULT) begin
                    state_d  = S_RUN;
                    mcand_d  = {{2{mul.is_signed & mul.data_operandA[WIDTH-1]}}, mul.data_operandA};
                    mplr_d   = {{2{mul.is_signed & mul.data_operandB[WIDTH-1]}}, mul.data_operandB};
                    acc_d    = '0;
                    guard_d  = 1'b0;
                    signed_d = mul.is_signed;
                    exc_d    = 1'b0;
                    cnt_d    = CW'(ITER);
                end
            end
            S_RUN: begin
                acc_d   = acc_sh;
                mplr_d  = mplr_sh;
                guard_d = mplr_q[1];
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    exc_d   = exc_fin;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplr_q   <= '0;
            guard_q  <= 1'b0;
            signed_q <= 1'b0;
            exc_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplr_q   <= mplr_d;
            guard_q  <= guard_d;
            signed_q <= signed_d;
            exc_q    <= exc_d;
            cnt_q    <= cnt_d;
        end
    end

    // After ITER double-shifts the low product bits live entirely in mplr, the high bits in acc.
    assign mul.data_result    = mplr_q[WIDTH-1:0];
    assign mul.data_result_hi = {acc_q[WIDTH-3:0], mplr_q[XW-1:WIDTH]};
    assign mul.data_exception = exc_q;
    assign mul.data_resultRDY = (state_q == S_DONE);
    assign mul.busy           = (state_q == S_RUN);
endmodule
